// File: rtl/id_gen.sv
// id_gen: serial ID body in, weighted check digit appended, 10-symbol ID out.
// Illegal bodies produce a single out_err pulse instead of a stream.
module id_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_id,
    output logic       in_ready,
    output logic       out_valid,
    output logic [5:0] out_id,
    output logic       out_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] acc_q, acc_d;
    logic       bad_q, bad_d;
    logic [3:0] chk_q, chk_d;
    logic [5:0] sym_q [9];
    logic [5:0] sym_d [9];
    logic       ov_q, ov_d;
    logic       oe_q, oe_d;
    logic [5:0] oid_q, oid_d;
    logic [5:0] sym_rd;
    logic       accept;

    function automatic logic [8:0] weight_add(
        input logic [3:0] k,
        input logic [5:0] s
    );
        logic [8:0] s9;
        s9 = {3'b000, s};
        if (k == 4'd0)
            return s9 / 9'd10 + (s9 % 9'd10) * 9'd9;
        else
            return s9 * (9'd9 - {5'b00000, k});
    endfunction

    function automatic logic illegal(
        input logic [3:0] k,
        input logic [5:0] s
    );
        if (k == 4'd0)
            return (s < 6'd10) || (s > 6'd35);
        else
            return s > 6'd9;
    endfunction

    // Hold off a new frame until the last output symbol has drained.
    assign in_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !ov_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sym_rd = '0;
        for (int i = 0; i < 9; i++)
            if (cnt_q == i[3:0])
                sym_rd = sym_q[i];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bad_d   = bad_q;
        chk_d   = chk_q;
        sym_d   = sym_q;
        ov_d    = 1'b0;
        oe_d    = 1'b0;
        oid_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sym_d[0] = in_id;
                    cnt_d    = 4'd1;
                    acc_d    = weight_add(4'd0, in_id);
                    bad_d    = illegal(4'd0, in_id);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    for (int i = 1; i < 9; i++)
                        if (cnt_q == i[3:0])
                            sym_d[i] = in_id;
                    acc_d = acc_q + weight_add(cnt_q, in_id);
                    bad_d = bad_q | illegal(cnt_q, in_id);
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd8)
                        state_d = S_CALC;
                end else begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    bad_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                chk_d   = 4'((9'd10 - acc_q % 9'd10) % 9'd10);
                cnt_d   = '0;
                state_d = bad_q ? S_ERR : S_SEND;
            end
            S_SEND: begin
                ov_d  = 1'b1;
                oid_d = (cnt_q == 4'd9) ? {2'b00, chk_q} : sym_rd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    bad_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                ov_d    = 1'b1;
                oe_d    = 1'b1;
                cnt_d   = '0;
                acc_d   = '0;
                bad_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            bad_q   <= 1'b0;
            chk_q   <= '0;
            ov_q    <= 1'b0;
            oe_q    <= 1'b0;
            oid_q   <= '0;
            for (int i = 0; i < 9; i++)
                sym_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bad_q   <= bad_d;
            chk_q   <= chk_d;
            ov_q    <= ov_d;
            oe_q    <= oe_d;
            oid_q   <= oid_d;
            for (int i = 0; i < 9; i++)
                sym_q[i] <= sym_d[i];
        end
    end

    assign out_valid = ov_q;
    assign out_err   = oe_q;
    assign out_id    = oid_q;

endmodule

// File: tb/tb_id_gen.sv
// tb_id_gen: directed and random frames against a weighted-sum reference model.
// Checks stream timing, error pulses, aborts, back-to-back frames and reset.
module tb_id_gen;

    typedef logic [5:0] body_t [9];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_id = '0;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_id;
    logic       out_err;

    int errors = 0;
    int checks = 0;

    id_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_id    (in_id),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_id   (out_id),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int body_sum(input body_t b);
        int s;
        s = int'(b[0]) / 10 + (int'(b[0]) % 10) * 9;
        for (int k = 1; k < 9; k++)
            s += int'(b[k]) * (9 - k);
        return s;
    endfunction

    function automatic int ref_chk(input body_t b);
        return (10 - body_sum(b) % 10) % 10;
    endfunction

    function automatic bit legal(input body_t b);
        if (b[0] < 10 || b[0] > 35) return 1'b0;
        for (int k = 1; k < 9; k++)
            if (b[k] > 9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input body_t b, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) check("ready_at_start", {15'd0, in_ready}, 16'd1);
            in_valid = 1'b1;
            in_id    = b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Entered at E8+1; leaves at the first cycle in_ready is back high.
    task automatic expect_frame(input body_t b, input bit hold);
        body_t ob;
        int    c;
        int    osum;
        if (hold) begin
            in_valid = 1'b1;
            in_id    = 6'($urandom);
        end
        check("ready_low_e8", {15'd0, in_ready}, 16'd0);
        @(posedge clk); #1;
        check("calc_quiet", {15'd0, out_valid}, 16'd0);
        if (legal(b)) begin
            c = ref_chk(b);
            osum = 0;
            for (int j = 0; j < 10; j++) begin
                @(posedge clk); #1;
                check("send_valid", {15'd0, out_valid}, 16'd1);
                check("send_err", {15'd0, out_err}, 16'd0);
                if (j < 9) begin
                    check("send_sym", {10'd0, out_id}, {10'd0, b[j]});
                    ob[j] = out_id;
                end else begin
                    check("send_chk", {10'd0, out_id}, 16'(c));
                    osum = body_sum(ob) + int'(out_id);
                end
                if (hold) in_id = 6'($urandom);
            end
            check("checker_accepts", 16'(osum % 10), 16'd0);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            check("err_valid", {15'd0, out_valid}, 16'd1);
            check("err_flag", {15'd0, out_err}, 16'd1);
            check("err_id", {10'd0, out_id}, 16'd0);
            check("err_ready_low", {15'd0, in_ready}, 16'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("end_valid_low", {15'd0, out_valid}, 16'd0);
        check("end_err_low", {15'd0, out_err}, 16'd0);
        check("end_ready", {15'd0, in_ready}, 16'd1);
    endtask

    task automatic run_frame(input body_t b, input bit hold);
        drive(b, 9);
        expect_frame(b, hold);
    endtask

    task automatic rand_body(output body_t b);
        int mode;
        mode = $urandom_range(3, 0);
        b[0] = 6'($urandom_range(35, 10));
        for (int k = 1; k < 9; k++)
            b[k] = 6'($urandom_range(9, 0));
        if (mode == 1)
            b[0] = ($urandom_range(1, 0) == 0) ? 6'($urandom_range(9, 0))
                                               : 6'($urandom_range(63, 36));
        if (mode == 2)
            b[$urandom_range(8, 1)] = 6'($urandom_range(63, 10));
    endtask

    initial begin
        body_t b;
        #3;
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_id", {10'd0, out_id}, 16'd0);
        check("rst_err", {15'd0, out_err}, 16'd0);
        check("rst_ready", {15'd0, in_ready}, 16'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        b = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
        run_frame(b, 1'b0);
        b = '{6'd10, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9};
        run_frame(b, 1'b0);
        b = '{6'd35, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9};
        run_frame(b, 1'b0);
        b = '{6'd9, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
        run_frame(b, 1'b0);
        b = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd10, 6'd5, 6'd6, 6'd7, 6'd8};
        run_frame(b, 1'b0);

        b = '{6'd20, 6'd3, 6'd1, 6'd4, 6'd1, 6'd5, 6'd9, 6'd2, 6'd6};
        drive(b, 5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", {15'd0, out_valid}, 16'd0);
            check("abort_ready", {15'd0, in_ready}, 16'd1);
        end
        b = '{6'd17, 6'd4, 6'd0, 6'd2, 6'd8, 6'd1, 6'd3, 6'd6, 6'd5};
        run_frame(b, 1'b1);
        b = '{6'd28, 6'd7, 6'd7, 6'd1, 6'd0, 6'd2, 6'd9, 6'd4, 6'd3};
        run_frame(b, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rand_body(b);
            run_frame(b, 1'(n % 3 == 0));
        end

        b = '{6'd23, 6'd5, 6'd5, 6'd2, 6'd7, 6'd3, 6'd1, 6'd8, 6'd0};
        drive(b, 9);
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            check("pre_rst_sym", {10'd0, out_id}, {10'd0, b[j]});
        end
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_id", {10'd0, out_id}, 16'd0);
        check("mid_rst_err", {15'd0, out_err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {15'd0, in_ready}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {15'd0, out_valid}, 16'd0);
        end
        b = '{6'd31, 6'd2, 6'd4, 6'd6, 6'd8, 6'd1, 6'd3, 6'd5, 6'd7};
        run_frame(b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
